// File: rtl/i2s_pkg.sv
// Shared constants, stereo word type and helpers for the I2S
// transmit scheduler.
package i2s_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SAMPLE_W   = 24;
    localparam int I2S_STEREO_W   = 2 * I2S_SAMPLE_W;
    localparam int I2S_BIT_CNT_W  = $clog2(I2S_FRAME_BITS);
    localparam int I2S_LR_BIT     = $clog2(I2S_SLOT_BITS);

    // {left[23:0], right[23:0]}
    typedef logic [I2S_STEREO_W-1:0] i2s_stereo_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider, edge strobes, bit counter and word clock.
// o_frame marks the CBfall cycle in which bit_cnt wraps to 0.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_cbrise,
    output logic o_cbfall,
    output logic o_lrclk,
    output logic o_frame
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    logic [7:0]               r_div_cnt;
    logic                     r_bclk_ph;
    logic                     r_cbrise;
    logic                     r_cbfall;
    logic [I2S_BIT_CNT_W-1:0] r_bit_cnt;
    logic                     w_tc;

    assign w_tc = (r_div_cnt == DIV_LAST);

    // Divider, phase toggle, registered strobes and bit count;
    // run low parks everything at zero.
    always_ff @(posedge clk) begin
        if (rst || !i_run) begin
            r_div_cnt <= '0;
            r_bclk_ph <= 1'b0;
            r_cbrise  <= 1'b0;
            r_cbfall  <= 1'b0;
            r_bit_cnt <= '0;
        end else begin
            r_div_cnt <= w_tc ? 8'd0 : r_div_cnt + 8'd1;
            r_cbrise  <= w_tc & ~r_bclk_ph;
            r_cbfall  <= w_tc & r_bclk_ph;
            if (w_tc) begin
                r_bclk_ph <= ~r_bclk_ph;
            end
            if (w_tc && r_bclk_ph) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_cbrise = r_cbrise;
    assign o_cbfall = r_cbfall;
    assign o_lrclk  = r_bit_cnt[I2S_LR_BIT];
    // Gate with run so a drop in the frame cycle raises no ready.
    assign o_frame  = r_cbfall & (r_bit_cnt == '0) & i_run;

endmodule

// File: rtl/i2s_tx_sched.sv
// I2S transmit scheduler: BCLK timing plus per-frame sample arbitration.
// Build option I2S_SCHED_HOLD_EN: repeat last sample on underrun.
module i2s_tx_sched
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [47:0] a_data,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [47:0] b_data,
    input  logic        b_valid,
    output logic        b_ready,
    output logic        CBrise,
    output logic        CBfall,
    output logic        lrclk,
    output logic [47:0] sample,
    output logic [15:0] underrun_cnt
);

    logic        w_frame;
    logic        w_underrun;
    i2s_stereo_t r_sample;
    logic [15:0] r_underrun_cnt;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk (
        .clk      (clk),
        .rst      (rst),
        .i_run    (run),
        .o_cbrise (CBrise),
        .o_cbfall (CBfall),
        .o_lrclk  (lrclk),
        .o_frame  (w_frame)
    );

    // Sidetone has priority; audio waits while sidetone is valid.
    assign b_ready    = w_frame & b_valid;
    assign a_ready    = w_frame & a_valid & ~b_valid;
    assign w_underrun = w_frame & ~a_valid & ~b_valid;

    // Sample register only moves at F+1, so it is stable all frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
        end else if (w_frame) begin
            if (b_valid) begin
                r_sample <= b_data;
            end else if (a_valid) begin
                r_sample <= a_data;
            end else begin
`ifdef I2S_SCHED_HOLD_EN
                r_sample <= r_sample;
`else
                r_sample <= '0;
`endif
            end
        end
    end

    // Saturating count of frames where nobody had data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun) begin
            r_underrun_cnt <= sat_inc16(r_underrun_cnt);
        end
    end

    assign sample       = r_sample;
    assign underrun_cnt = r_underrun_cnt;

endmodule
